// File: rtl/rob_commit_source.sv
// rob_commit_source: reorder buffer that allocates from 2-wide dispatch, completes from
// 2 writeback ports and presents the two oldest entries to the commit stage.
`default_nettype none

module rob_commit_source #(
    parameter int DEPTH     = 64,
    parameter int PAYLOAD_W = 64,
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic [1:0]             dispatch_valid_i,
    input  logic [1:0]             dispatch_single_i,
    input  logic [2*PAYLOAD_W-1:0] dispatch_payload_i,
    output logic                   dispatch_ready_o,
    output logic [2*IDX_W-1:0]     dispatch_idx_o,
    input  logic [1:0]             wb_valid_i,
    input  logic [2*IDX_W-1:0]     wb_idx_i,
    input  logic [1:0]             wb_except_i,
    output logic [1:0]             commit_valid_o,
    output logic [1:0]             commit_first_o,
    output logic [1:0]             commit_except_o,
    output logic [2*PAYLOAD_W-1:0] commit_payload_o,
    input  logic [1:0]             commit_request_i,
    output logic [IDX_W:0]         count_o,
    output logic                   empty_o
);

    logic [IDX_W:0]         head, tail, count;
    logic [DEPTH-1:0]       valid, complete, single, except;
    logic [PAYLOAD_W-1:0]   payload [DEPTH];
    logic [IDX_W-1:0]       h0, h1, t0, t1, wi0, wi1;
    logic [DEPTH-1:0]       wb_hit, wb_exc;
    logic                   do_disp;
    logic [1:0]             alloc, pop;

    // Pointers carry a wrap bit, so the difference is the occupancy even when full.
    assign count   = tail - head;
    assign count_o = count;
    assign empty_o = (count == '0);

    assign h0  = head[IDX_W-1:0];
    assign h1  = h0 + 1'b1;
    assign t0  = tail[IDX_W-1:0];
    assign t1  = t0 + 1'b1;
    assign wi0 = wb_idx_i[IDX_W-1:0];
    assign wi1 = wb_idx_i[2*IDX_W-1:IDX_W];

    assign dispatch_ready_o = (count <= (IDX_W+1)'(DEPTH-2));
    assign dispatch_idx_o   = {t1, t0};
    assign do_disp          = dispatch_ready_o && dispatch_valid_i[0];
    assign alloc            = do_disp ? (dispatch_valid_i[1] ? 2'd2 : 2'd1) : 2'd0;

    assign commit_valid_o   = {valid[h1] & complete[h1], valid[h0] & complete[h0]};
    assign commit_first_o   = {single[h1] | except[h1], single[h0] | except[h0]};
    assign commit_except_o  = {except[h1], except[h0]};
    assign commit_payload_o = {payload[h1], payload[h0]};

    always_comb begin
        pop = 2'd0;
        if (commit_request_i == 2'b01 && commit_valid_o[0])
            pop = 2'd1;
        else if (commit_request_i == 2'b11 && commit_valid_o == 2'b11)
            pop = 2'd2;
    end

    // Both ports may hit the same entry; their flags simply OR together.
    always_comb begin
        wb_hit = '0;
        wb_exc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wb_hit[i] = valid[i] && ((wb_valid_i[0] && wi0 == IDX_W'(i)) ||
                                     (wb_valid_i[1] && wi1 == IDX_W'(i)));
            wb_exc[i] = valid[i] && ((wb_valid_i[0] && wb_except_i[0] && wi0 == IDX_W'(i)) ||
                                     (wb_valid_i[1] && wb_except_i[1] && wi1 == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            valid    <= '0;
            complete <= '0;
            single   <= '0;
            except   <= '0;
        end else if (flush_i) begin
            head     <= '0;
            tail     <= '0;
            valid    <= '0;
            complete <= '0;
            except   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_hit[i]) complete[i] <= 1'b1;
                if (wb_exc[i]) except[i]   <= 1'b1;
            end
            if (pop != 2'd0) begin
                valid[h0]    <= 1'b0;
                complete[h0] <= 1'b0;
            end
            if (pop == 2'd2) begin
                valid[h1]    <= 1'b0;
                complete[h1] <= 1'b0;
            end
            // Ready is judged on pre-retire count, so dispatch never lands on a retiring entry.
            if (do_disp) begin
                valid[t0]    <= 1'b1;
                complete[t0] <= 1'b0;
                except[t0]   <= 1'b0;
                single[t0]   <= dispatch_single_i[0];
                if (dispatch_valid_i[1]) begin
                    valid[t1]    <= 1'b1;
                    complete[t1] <= 1'b0;
                    except[t1]   <= 1'b0;
                    single[t1]   <= dispatch_single_i[1];
                end
            end
            head <= head + (IDX_W+1)'(pop);
            tail <= tail + (IDX_W+1)'(alloc);
        end
    end

    always_ff @(posedge clk) begin
        if (!flush_i && do_disp) begin
            payload[t0] <= dispatch_payload_i[PAYLOAD_W-1:0];
            if (dispatch_valid_i[1])
                payload[t1] <= dispatch_payload_i[2*PAYLOAD_W-1:PAYLOAD_W];
        end
    end

endmodule

`default_nettype wire
